// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {StOff, StDead, StShow} seg_state_e;

  localparam int unsigned NIB_W = 4;

  // Width of a counter that must hold 0..slot_cycles-1.
  function automatic int unsigned cnt_width(input int unsigned slot_cycles);
    return (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot prescaler: flags the last blanking cycle and the slot terminal count.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic dead_end_o,
  output logic tc_o,
  output logic tc_next_o
);

  localparam int unsigned CntW = cnt_width(SLOT_CYCLES);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign dead_end_o = (cnt_q == DeadLast);
  assign tc_o       = (cnt_q == SlotLast);
  // Lets the owner register a flag that lines up with the terminal-count cycle.
  assign tc_next_o  = (cnt_d == SlotLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with frame-aligned display word swap.
// Optional: define LEADING_ZERO_BLANK_EN to keep digits above the highest nonzero one dark.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SLOT_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr_valid,
  input  logic [NIB_W*NUM_DIGITS-1:0]   wr_data,
  output logic                          wr_ready,
  output logic [NIB_W-1:0]              nib,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);

  localparam int unsigned WordW = NIB_W * NUM_DIGITS;
  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  seg_state_e            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [WordW-1:0]      disp_q, disp_d, pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic                  wr_ready_q;
  logic                  frame_done_q, frame_done_d;
  logic [NIB_W-1:0]      nib_q, nib_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dead_end, tc, tc_next, xfer, swap, lit;

  seg_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (en && (state_q != StOff)),
    .clr_i     (!en),
    .dead_end_o(dead_end),
    .tc_o      (tc),
    .tc_next_o (tc_next)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StOff:  if (en) state_d = StDead;
      StDead: begin
        if (!en) state_d = StOff;
        else if (dead_end) state_d = StShow;
      end
      StShow: begin
        if (!en) begin
          state_d = StOff;
        end else if (tc) begin
          state_d = StDead;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Transfer and swap are exclusive: wr_ready is low whenever a word is pending.
  assign xfer = wr_valid && wr_ready_q;
  assign swap = pend_full_q && (frame_done_q || (state_q == StOff));

  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (xfer) begin
      pend_d      = wr_data;
      pend_full_d = 1'b1;
    end else if (swap) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IdxW-1:0] hi_q, hi_d;

  function automatic logic [IdxW-1:0] hi_digit(input logic [WordW-1:0] w);
    logic [IdxW-1:0] h;
    h = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (w[i*NIB_W +: NIB_W] != '0) h = IdxW'(i);
    end
    return h;
  endfunction

  assign hi_d = swap ? hi_digit(pend_q) : hi_q;
  assign lit  = (idx_d <= hi_d);

  always_ff @(posedge clk) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end
`else
  assign lit = 1'b1;
`endif

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    an_d = '1;
    if ((state_d == StShow) && lit) an_d[idx_d] = 1'b0;
    nib_d        = disp_d[idx_d*NIB_W +: NIB_W];
    frame_done_d = (state_d == StShow) && tc_next && (idx_d == IdxLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StOff;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      wr_ready_q   <= 1'b1;
      an_q         <= '1;
      nib_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      wr_ready_q   <= !pend_full_d;
      an_q         <= an_d;
      nib_q        <= nib_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign an         = an_q;
  assign nib        = nib_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl (8 digits, 4-cycle slots, 1 dead cycle).
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int ND    = 8;
  localparam int SC    = 4;
  localparam int DC    = 1;
  localparam int FRAME = ND * SC;
  localparam int NF    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [3:0]  nib;
  logic [7:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SLOT_CYCLES(SC),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .nib       (nib),
    .an        (an),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot k of a frame shows digit k/SC; the first DC cycles are dark.
  function automatic int hi_of(input logic [31:0] w);
    int h;
    h = ND - 1;
`ifdef LEADING_ZERO_BLANK_EN
    h = 0;
    for (int i = 1; i < ND; i++) begin
      if (((w >> (4 * i)) & 32'hF) != 0) h = i;
    end
`endif
    return h;
  endfunction

  function automatic logic [7:0] exp_an(input logic [31:0] w, input int k);
    int dig;
    logic [7:0] a;
    dig = k / SC;
    a = 8'hFF;
    if ((k % SC) >= DC && dig <= hi_of(w)) a[dig] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [31:0] w, input int k);
    return 4'((w >> (4 * (k / SC))) & 32'hF);
  endfunction

  // Monitor: logs a whole frame, compares it against the queued word at frame_done.
  logic [7:0]  an_log [FRAME];
  logic [3:0]  nib_log[FRAME];
  int          k = 0;
  int          an_bad, nib_bad;
  logic [31:0] mon_w;

  always @(negedge clk) begin
    if (!mon_en) begin
      k = 0;
    end else begin
      an_log[k]  = an;
      nib_log[k] = nib;
      if (frame_done) begin
        chk("frame_len", k, FRAME - 1);
        chk("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_w   = exp_q.pop_front();
          an_bad  = 0;
          nib_bad = 0;
          for (int j = 0; j < FRAME; j++) begin
            if (an_log[j] !== exp_an(mon_w, j)) an_bad++;
            if (nib_log[j] !== exp_nib(mon_w, j)) nib_bad++;
          end
          chk("frame_an_errs", an_bad, 0);
          chk("frame_nib_errs", nib_bad, 0);
        end
        k = 0;
      end else begin
        k++;
        if (k >= FRAME) begin
          chk("frame_done_missing", k, FRAME - 1);
          k = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] shown, pend_word;
    bit pend_has, xfer_now, dbl;
    int off, bad, n;

    // Reset and an idle write while scanning is off.
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_nib", nib, 4'h0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("off_an0", an, 8'hFF);
    wr_valid = 1'b1;
    wr_data  = 32'h12345678;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("off_ready_busy", wr_ready, 1'b0);
    chk("off_an1", an, 8'hFF);
    @(negedge clk);
    chk("off_ready_back", wr_ready, 1'b1);
    chk("off_an2", an, 8'hFF);
    shown    = 32'h12345678;
    pend_has = 1'b0;
    xfer_now = 1'b0;

    // Continuous scanning with random writes; words take effect one frame later.
    en = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;
    for (int f = 0; f < NF; f++) begin
      off = $urandom_range(0, 25);
      dbl = (f == 0) || (f == 5);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if (xfer_now) begin
          wr_valid = 1'b0;
          xfer_now = 1'b0;
        end
        if (c == 0) begin
          if (pend_has) begin
            shown    = pend_word;
            pend_has = 1'b0;
          end
          exp_q.push_back(shown);
        end
        chk("scan_ready", wr_ready, !pend_has);
        if (f < NF - 2 && !wr_valid && c == off) begin
          wr_valid = 1'b1;
          wr_data  = (f == 0) ? 32'hAAAAAAAA : (f == 2) ? 32'h00000042 :
                     (f == 4) ? 32'h0 : $urandom;
        end else if (f < NF - 2 && dbl && !wr_valid && c == off + 1) begin
          wr_valid = 1'b1;
          wr_data  = $urandom;
        end
        if (wr_valid && !pend_has) begin
          pend_word = wr_data;
          pend_has  = 1'b1;
          xfer_now  = 1'b1;
        end
      end
    end

    // Drop en during SHOW of digit 3, then resume at its dead cycle.
    @(posedge clk);
    mon_en = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_drop_an", an, exp_an(shown, 13));
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) bad++;
      if (frame_done !== 1'b0) bad++;
    end
    chk("en_low_dark", bad, 0);
    en = 1'b1;
    for (int j = 0; j < SC; j++) begin
      @(negedge clk);
      chk("resume_an", an, exp_an(shown, 3 * SC + j));
      chk("resume_nib", nib, exp_nib(shown, 3 * SC + j));
    end
    n = 0;
    while (!frame_done && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("resume_frame_done", n, (ND - 4) * SC);

    // Pending write plus reset mid-slot: everything returns to reset values.
    wr_valid = 1'b1;
    wr_data  = $urandom | 32'h1;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_nib", nib, 4'h0);
    chk("midrst_fd", frame_done, 1'b0);
    chk("midrst_ready", wr_ready, 1'b1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (an !== 8'hFF || frame_done !== 1'b0 || nib !== 4'h0 || wr_ready !== 1'b1) bad++;
    end
    chk("post_rst_idle", bad, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
